// File: rtl/grant_bus_mux_pkg.sv
// Shared definitions for the grant-driven bus multiplexer: client count,
// select width, FSM state encoding and a small popcount helper.
package grant_bus_mux_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int SEL_W       = 2;

    // Output-stage condition: empty, moving, or held by downstream backpressure
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Number of set bits in a client-wide vector
    function automatic logic [2:0] popcount4(input logic [NUM_CLIENTS-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/grant_bus_mux_onehot_enc.sv
// One-hot to binary encoder. valid is high only when exactly one input
// bit is set; idx is meaningful only in that case.
module onehot_enc
    import grant_bus_mux_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] onehot,
    output logic [SEL_W-1:0]       idx,
    output logic                   valid
);

    // Encode the set bit and qualify it with an exactly-one test
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (onehot[i]) begin
                idx = SEL_W'(i);
            end
        end
        valid = (popcount4(onehot) == 3'd1);
    end

endmodule

// File: rtl/grant_bus_mux.sv
// Grant-steered bus multiplexer: forwards the granted client's word into a
// single registered output stage with valid/ready handshaking, counts beats
// per grant tenure and pulses tenure_done when a productive tenure ends.
// Optional feature macro: GRANT_MUX_ONEHOT_CHK_EN enables the sticky
// onehot_err flag for multi-bit grants; otherwise onehot_err is tied to 0.
module grant_bus_mux
    import grant_bus_mux_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CLIENTS-1:0]    grant,
    input  logic [NUM_CLIENTS*DW-1:0] din,
    input  logic [NUM_CLIENTS-1:0]    din_vld,
    output logic [NUM_CLIENTS-1:0]    din_rdy,
    output logic [DW-1:0]             dout,
    output logic                      dout_vld,
    input  logic                      dout_rdy,
    output logic [SEL_W-1:0]          dout_src,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic                      tenure_done,
    output logic                      onehot_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SEL_W-1:0]       sel;
    logic                   grant_valid;
    logic                   out_free;
    logic                   accept;
    logic                   tenure_change;
    logic [DW-1:0]          din_words [NUM_CLIENTS];

    logic [DW-1:0]          dout_reg,        dout_next;
    logic                   dout_vld_reg,    dout_vld_next;
    logic [SEL_W-1:0]       dout_src_reg,    dout_src_next;
    logic [CNT_W-1:0]       beat_cnt_reg,    beat_cnt_next;
    logic                   tenure_done_reg, tenure_done_next;
    logic [NUM_CLIENTS-1:0] prev_grant_reg;
    state_t                 state_reg;

    onehot_enc u_enc (
        .onehot (grant),
        .idx    (sel),
        .valid  (grant_valid)
    );

    // The output register can take a new word when empty or being drained
    assign out_free = ~dout_vld_reg | dout_rdy;

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            assign din_words[gi] = din[gi*DW +: DW];
            assign din_rdy[gi]   = grant_valid & grant[gi] & out_free;
        end
    endgenerate

    assign accept        = grant_valid & din_vld[sel] & out_free;
    assign tenure_change = (grant != prev_grant_reg);

    // Next values for the output stage, beat counter and tenure pulse
    always_comb begin
        dout_next        = dout_reg;
        dout_src_next    = dout_src_reg;
        dout_vld_next    = dout_vld_reg;
        beat_cnt_next    = beat_cnt_reg;
        tenure_done_next = 1'b0;

        if (accept) begin
            dout_next     = din_words[sel];
            dout_src_next = sel;
            dout_vld_next = 1'b1;
        end else if (dout_vld_reg && dout_rdy) begin
            dout_vld_next = 1'b0;
        end

        if (tenure_change) begin
            beat_cnt_next    = accept ? CNT_W'(1) : '0;
            tenure_done_next = (prev_grant_reg != '0) && (beat_cnt_reg != '0);
        end else if (accept && (beat_cnt_reg != CNT_MAX)) begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
    end

    // Register the output stage, counter, pulse and previous grant
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg        <= '0;
            dout_src_reg    <= '0;
            dout_vld_reg    <= 1'b0;
            beat_cnt_reg    <= '0;
            tenure_done_reg <= 1'b0;
            prev_grant_reg  <= '0;
        end else begin
            dout_reg        <= dout_next;
            dout_src_reg    <= dout_src_next;
            dout_vld_reg    <= dout_vld_next;
            beat_cnt_reg    <= beat_cnt_next;
            tenure_done_reg <= tenure_done_next;
            prev_grant_reg  <= grant;
        end
    end

    // Track output-stage condition; STALL reflects a full register left
    // unconsumed after the update of the current cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (dout_vld_next && !dout_rdy) begin
                        state_reg <= STALL;
                    end else if (!dout_vld_next && !grant_valid) begin
                        state_reg <= IDLE;
                    end
                end
                STALL: begin
                    if (dout_rdy) begin
                        state_reg <= BUSY;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef GRANT_MUX_ONEHOT_CHK_EN
    logic onehot_err_reg;

    // Sticky detection of more than one grant bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err_reg <= 1'b0;
        end else if (popcount4(grant) > 3'd1) begin
            onehot_err_reg <= 1'b1;
        end
    end

    assign onehot_err = onehot_err_reg;
`else
    assign onehot_err = 1'b0;
`endif

    assign dout        = dout_reg;
    assign dout_vld    = dout_vld_reg;
    assign dout_src    = dout_src_reg;
    assign beat_cnt    = beat_cnt_reg;
    assign tenure_done = tenure_done_reg;

endmodule

// File: tb/tb_grant_bus_mux.sv
// Self-checking bench for grant_bus_mux: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural reference model.
// Honours GRANT_MUX_ONEHOT_CHK_EN for the onehot_err expectation.
module tb_grant_bus_mux;
    import grant_bus_mux_pkg::*;

    localparam int DW    = 8;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        grant = '0;
    logic [4*DW-1:0]   din = '0;
    logic [3:0]        din_vld = '0;
    logic [3:0]        din_rdy;
    logic [DW-1:0]     dout;
    logic              dout_vld;
    logic              dout_rdy = 1'b0;
    logic [1:0]        dout_src;
    logic [CNT_W-1:0]  beat_cnt;
    logic              tenure_done;
    logic              onehot_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_dout = '0;
    logic          m_vld = 1'b0;
    int            m_src = 0;
    int            m_cnt = 0;
    logic          m_tdone = 1'b0;
    logic [3:0]    m_prev = '0;
    logic          m_oherr = 1'b0;

    grant_bus_mux #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .grant       (grant),
        .din         (din),
        .din_vld     (din_vld),
        .din_rdy     (din_rdy),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .dout_rdy    (dout_rdy),
        .dout_src    (dout_src),
        .beat_cnt    (beat_cnt),
        .tenure_done (tenure_done),
        .onehot_err  (onehot_err)
    );

    always #5 clk = ~clk;

    // Expected ready vector from the current inputs and model occupancy
    function automatic logic [3:0] exp_rdy();
        if ($countones(grant) == 1 && (!m_vld || dout_rdy)) return grant;
        return 4'b0000;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic step();
        int         s;
        bit         acc, chg;
        logic [DW-1:0] n_dout;
        logic       n_vld, n_tdone, n_oherr;
        int         n_src, n_cnt;
        s = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) s = i;
        acc = ($countones(grant) == 1) && din_vld[s] && (!m_vld || dout_rdy);
        chg = (grant != m_prev);
        n_dout = m_dout; n_vld = m_vld; n_src = m_src; n_cnt = m_cnt;
        if (acc) begin
            n_dout = din[s*DW +: DW];
            n_src  = s;
            n_vld  = 1'b1;
        end else if (m_vld && dout_rdy) begin
            n_vld = 1'b0;
        end
        if (chg) n_cnt = acc ? 1 : 0;
        else if (acc) n_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        n_tdone = chg && (m_prev != 0) && (m_cnt > 0);
`ifdef GRANT_MUX_ONEHOT_CHK_EN
        n_oherr = m_oherr || ($countones(grant) > 1);
`else
        n_oherr = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            m_dout = '0; m_vld = 1'b0; m_src = 0; m_cnt = 0;
            m_tdone = 1'b0; m_prev = '0; m_oherr = 1'b0;
        end else begin
            m_dout = n_dout; m_vld = n_vld; m_src = n_src; m_cnt = n_cnt;
            m_tdone = n_tdone; m_prev = grant; m_oherr = n_oherr;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; grant = '0; din_vld = '0; dout_rdy = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (dout_vld !== 1'b0 || dout !== '0 || dout_src !== '0) begin
            errors++;
            $display("FAIL reset_out: vld=%0b dout=%h src=%0d required 0/00/0", dout_vld, dout, dout_src);
        end
        checks++;
        if (beat_cnt !== '0 || tenure_done !== 1'b0 || onehot_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: cnt=%0d tdone=%0b oherr=%0b required 0/0/0", beat_cnt, tenure_done, onehot_err);
        end
        checks++;
        if (dut.state_reg !== IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", dut.state_reg, IDLE);
        end
        checks++;
        if (din_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rdy: din_rdy=%b required 0000", din_rdy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        grant = 4'b0001; din_vld = 4'b0001; din = '0; din[7:0] = 8'hA5; dout_rdy = 1'b1;
        step();
        checks++;
        if (dout !== 8'hA5 || dout_src !== 2'd0 || dout_vld !== 1'b1 || beat_cnt !== 3'd1) begin
            errors++;
            $display("FAIL single_beat: dout=%h src=%0d vld=%0b cnt=%0d required a5/0/1/1", dout, dout_src, dout_vld, beat_cnt);
        end
        grant = 4'b0000; din_vld = '0;
        step();
        step();
        $display("test_single_beat dout=%h", 8'hA5);
    endtask

    task automatic test_backpressure();
        grant = 4'b0100; din_vld = 4'b0100; din = '0; din[23:16] = 8'h11; dout_rdy = 1'b1;
        step();
        dout_rdy = 1'b0; din[23:16] = 8'h22;
        #1;
        checks++;
        if (din_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL bp_rdy: din_rdy=%b required 0000", din_rdy);
        end
        step(); step(); step();
        checks++;
        if (dout !== 8'h11 || dout_vld !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: dout=%h vld=%0b required 11/1", dout, dout_vld);
        end
        checks++;
        if (dut.state_reg !== STALL) begin
            errors++;
            $display("FAIL bp_state: state=%0d required %0d", dut.state_reg, STALL);
        end
        dout_rdy = 1'b1;
        step();
        checks++;
        if (dout !== 8'h22 || dout_vld !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: dout=%h vld=%0b required 22/1", dout, dout_vld);
        end
        din[23:16] = 8'h33;
        step();
        checks++;
        if (dout !== 8'h33 || dout_vld !== 1'b1 || beat_cnt !== 3'd3) begin
            errors++;
            $display("FAIL bp_third: dout=%h vld=%0b cnt=%0d required 33/1/3", dout, dout_vld, beat_cnt);
        end
        din_vld = '0;
        step();
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: vld=%0b required 0", dout_vld);
        end
        $display("test_backpressure beats 11 22 33");
    endtask

    task automatic test_tenure_switch();
        grant = 4'b0000; din_vld = '0; dout_rdy = 1'b1;
        step(); step();
        grant = 4'b0010; din_vld = 4'b0010; din = '0; din[15:8] = 8'h41;
        step();
        checks++;
        if (tenure_done !== 1'b0 || beat_cnt !== 3'd1) begin
            errors++;
            $display("FAIL ten_first: tdone=%0b cnt=%0d required 0/1", tenure_done, beat_cnt);
        end
        din[15:8] = 8'h42;
        step();
        grant = 4'b1000; din_vld = 4'b1000; din[31:24] = 8'h77;
        step();
        checks++;
        if (tenure_done !== 1'b1 || beat_cnt !== 3'd1 || dout_src !== 2'd3 || dout !== 8'h77) begin
            errors++;
            $display("FAIL ten_switch: tdone=%0b cnt=%0d src=%0d dout=%h required 1/1/3/77", tenure_done, beat_cnt, dout_src, dout);
        end
        step();
        checks++;
        if (tenure_done !== 1'b0 || beat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL ten_after: tdone=%0b cnt=%0d required 0/2", tenure_done, beat_cnt);
        end
        $display("test_tenure_switch 0010->1000");
    endtask

    task automatic test_illegal_grant();
        logic exp_err;
`ifdef GRANT_MUX_ONEHOT_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        grant = 4'b0011; din_vld = 4'b0011; dout_rdy = 1'b1;
        #1;
        checks++;
        if (din_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL illegal_rdy: din_rdy=%b required 0000", din_rdy);
        end
        step();
        step();
        checks++;
        if (dout_vld !== 1'b0 || beat_cnt !== 3'd0) begin
            errors++;
            $display("FAIL illegal_accept: vld=%0b cnt=%0d required 0/0", dout_vld, beat_cnt);
        end
        checks++;
        if (onehot_err !== exp_err) begin
            errors++;
            $display("FAIL illegal_err: oherr=%0b required %0b", onehot_err, exp_err);
        end
        grant = 4'b0001; din_vld = 4'b0000;
        step(); step();
        checks++;
        if (onehot_err !== exp_err) begin
            errors++;
            $display("FAIL illegal_sticky: oherr=%0b required %0b", onehot_err, exp_err);
        end
        $display("test_illegal_grant oherr=%0b", onehot_err);
    endtask

    task automatic test_saturation_reset();
        grant = 4'b0000; din_vld = '0; dout_rdy = 1'b1;
        step();
        grant = 4'b0001; din_vld = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            din[7:0] = DW'($urandom);
            step();
            checks++;
            if (beat_cnt !== CNT_W'((i > CMAX) ? CMAX : i)) begin
                errors++;
                $display("FAIL sat_cnt: beat %0d cnt=%0d required %0d", i, beat_cnt, (i > CMAX) ? CMAX : i);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dout_vld !== 1'b0 || dout !== '0 || dout_src !== '0 || beat_cnt !== '0 ||
            tenure_done !== 1'b0 || onehot_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: vld=%0b dout=%h src=%0d cnt=%0d tdone=%0b oherr=%0b required all 0",
                     dout_vld, dout, dout_src, beat_cnt, tenure_done, onehot_err);
        end
        checks++;
        if (dut.state_reg !== IDLE) begin
            errors++;
            $display("FAIL midreset_state: state=%0d required %0d", dut.state_reg, IDLE);
        end
        checks++;
        if (din_rdy !== exp_rdy()) begin
            errors++;
            $display("FAIL midreset_rdy: din_rdy=%b required %b", din_rdy, exp_rdy());
        end
        $display("test_saturation_reset cnt stopped at %0d", CMAX);
    endtask

    task automatic test_random();
        int r;
        logic [3:0] g;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 7) g = 4'b0001 << $urandom_range(0, 3);
                else if (r == 7) g = 4'b0000;
                else begin
                    g = 4'($urandom);
                    if ($countones(g) < 2) g = 4'b0110;
                end
                grant = g;
            end
            din      = (4*DW)'({$urandom, $urandom});
            din_vld  = 4'($urandom);
            dout_rdy = ($urandom_range(0, 2) != 0);
            rst      = ($urandom_range(0, 59) == 0);
            #1;
            checks++;
            if (din_rdy !== exp_rdy()) begin
                errors++;
                $display("FAIL rnd_rdy: cycle %0d din_rdy=%b required %b", cyc, din_rdy, exp_rdy());
            end
            step();
            checks++;
            if (dout_vld !== m_vld || dout !== m_dout || dout_src !== 2'(m_src)) begin
                errors++;
                $display("FAIL rnd_out: cycle %0d vld=%0b dout=%h src=%0d required %0b/%h/%0d",
                         cyc, dout_vld, dout, dout_src, m_vld, m_dout, m_src);
            end
            checks++;
            if (beat_cnt !== CNT_W'(m_cnt) || tenure_done !== m_tdone || onehot_err !== m_oherr) begin
                errors++;
                $display("FAIL rnd_cnt: cycle %0d cnt=%0d tdone=%0b oherr=%0b required %0d/%0b/%0b",
                         cyc, beat_cnt, tenure_done, onehot_err, m_cnt, m_tdone, m_oherr);
            end
        end
        rst = 1'b0;
        $display("test_random 400 cycles");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_tenure_switch();
        test_illegal_grant();
        test_saturation_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_bus_mux.md
GRANT_BUS_MUX -- requirements
Module: grant_bus_mux

Interface
REQ-001 Parameter DW, default 8, sets the data width of each client word.
REQ-002 Parameter CNT_W, default 8, sets the width of the beat counter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 grant  in  4  one-hot grant from the round-robin arbiter; bit i selects client i.
REQ-006 din  in  4*DW  client data, flattened; client i occupies bits [i*DW +: DW].
REQ-007 din_vld  in  4  per-client valid.
REQ-008 din_rdy  out  4  per-client ready, combinational.
REQ-009 dout  out  DW  forwarded data, registered.
REQ-010 dout_vld  out  1  forwarded valid, registered.
REQ-011 dout_rdy  in  1  downstream ready.
REQ-012 dout_src  out  2  encoded index of the client that produced dout.
REQ-013 beat_cnt  out  CNT_W  count of beats accepted in the current grant tenure.
REQ-014 tenure_done  out  1  one-cycle pulse marking the end of a grant tenure.
REQ-015 onehot_err  out  1  sticky flag for an illegal multi-bit grant; present only under the configuration macro.

Function
REQ-016 The block SHALL define grant as valid when exactly one bit of grant is set; sel SHALL be the encoded index of that bit.
REQ-017 The block SHALL compute din_rdy[i] = valid grant & grant[i] & (~dout_vld | dout_rdy); all other din_rdy bits SHALL be 0.
REQ-018 The block SHALL define an accept as din_vld[sel] & din_rdy[sel] in a cycle.
REQ-019 On an accept, the next cycle SHALL show dout = din[sel], dout_src = sel and dout_vld = 1; latency is 1 cycle.
REQ-020 When dout_vld & dout_rdy with no accept, dout_vld SHALL drop to 0 on the next cycle.
REQ-021 While dout_vld & ~dout_rdy, dout, dout_src and dout_vld SHALL hold unchanged.
REQ-022 A grant of 0 or a multi-bit grant SHALL be treated as no grant: no accepts, and the output register drains normally.
REQ-023 FSM states:
- IDLE: output empty, no valid grant.
- BUSY: valid grant or output full with dout_rdy high.
- STALL: output full and dout_rdy low.
REQ-024 FSM transitions:
- IDLE->BUSY on valid grant.
- BUSY->STALL when dout_vld & ~dout_rdy after update.
- STALL->BUSY when dout_rdy rises.
- BUSY->IDLE when output is empty and no valid grant.
REQ-025 The block SHALL keep a registered prev_grant; a tenure change occurs when grant != prev_grant.
REQ-026 On a tenure change, beat_cnt SHALL load 1 if an accept happens in that cycle, else 0.
REQ-027 Without a tenure change, beat_cnt SHALL increment on each accept and saturate at 2^CNT_W-1.
REQ-028 tenure_done SHALL pulse for exactly one cycle, in the cycle after a change in which prev_grant was nonzero and beat_cnt was >0.
REQ-029 A grant change while the output is stalled SHALL NOT corrupt dout; the new client is accepted only once the register frees.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL clear dout_vld, dout, dout_src, beat_cnt, tenure_done, prev_grant and onehot_err to 0 and set the FSM to IDLE.
REQ-031 A reset mid-transfer SHALL discard the in-flight beat; din_rdy SHALL follow REQ-017 from the state just reset, with no special handling.

Configuration
REQ-032 Macro GRANT_MUX_ONEHOT_CHK_EN: when defined, onehot_err SHALL set on any cycle with popcount(grant) > 1 and stay set until reset.
REQ-033 When GRANT_MUX_ONEHOT_CHK_EN is undefined, the onehot_err port SHALL exist and be tied to 0.

Structure
REQ-034 The shared package SHALL hold the FSM state encoding (IDLE, BUSY, STALL), the client count constant (4) and the sel width (2).
REQ-035 Sub-module onehot_enc SHALL convert 4-bit one-hot to 2-bit index plus a valid flag; all remaining logic stays in grant_bus_mux.

Verification
REQ-036 The bench SHALL cover each of the following directed scenarios:
- Single beat: grant=0001, din_vld=0001, client0 data=0xA5, dout_rdy=1 -> next cycle dout=0xA5, dout_src=0, dout_vld=1, beat_cnt=1.
- Backpressure: grant=0100, 3 beats 0x11/0x22/0x33 with dout_rdy held low after the first -> dout holds 0x11, din_rdy[2]=0, FSM=STALL; after release, 0x22 then 0x33 appear in order.
- Tenure switch: grant 0010 for 2 beats then 1000 -> tenure_done pulses once, one cycle after the switch; beat_cnt restarts at 1 with dout_src=3.
- Illegal grant: grant=0011 -> din_rdy=0000, no accept; with macro onehot_err=1 and sticky, without it onehot_err=0.
- Saturation/reset: CNT_W=3, 9 beats in one tenure -> beat_cnt stops at 7; rst asserted while dout_vld=1 -> next cycle all outputs 0, FSM=IDLE.
